// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a 32-bit dual-port RAM (sync read, big-endian lane packing).
// Define MEM_ACCESS_UNIT_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them down.
module mem_access_unit #(
    parameter int RAM_A_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic                   isStore,
    input  logic [2:0]             funct3,
    input  logic [31:0]            address,
    input  logic [31:0]            storeData,
    output logic                   done,
    output logic [31:0]            loadData,
    output logic                   accessFault,
    output logic [RAM_A_WIDTH-1:0] ramReadAddress,
    input  logic [31:0]            ramDataOut,
    output logic [RAM_A_WIDTH-1:0] ramWriteAddress,
    output logic [31:0]            ramDataIn,
    output logic                   ramWriteEnable
);
    localparam int BA_W = RAM_A_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, LOAD_WAIT, LOAD_DONE, STORE, FAULT} state_t;

    state_t            r_state, w_next;
    logic              r_isStore;
    logic [2:0]        r_funct3;
    logic [BA_W-1:0]   r_addr;
    logic [31:0]       r_storeData;
    logic [31:0]       r_loadData;

    logic              w_illegal, w_misalign, w_fault, w_accept;
    logic [BA_W-1:0]   w_addr_eff;
    logic [3:0][7:0]   w_rb;
    logic [3:0][7:0]   w_wb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_fmt;
    logic [1:0]        w_off;
    logic              w_unused;

    assign w_unused = &{1'b0, address[31:BA_W]};
    assign w_accept = (r_state == IDLE) && reqValid;

    always_comb begin
        w_illegal = 1'b0;
        if (isStore) w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        else         w_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    end

`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
    assign w_misalign = ((funct3[1:0] == 2'b01) && address[0]) ||
                        ((funct3 == 3'b010) && (address[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_fault = w_illegal | w_misalign;

    // Align down H/W; with the trap enabled the misaligned cases never reach a RAM state.
    always_comb begin
        w_addr_eff = address[BA_W-1:0];
        if (funct3[1:0] == 2'b01) w_addr_eff[0]   = 1'b0;
        if (funct3[1:0] == 2'b10) w_addr_eff[1:0] = 2'b00;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (reqValid) w_next = w_fault ? FAULT : (isStore ? STORE : LOAD_WAIT);
            LOAD_WAIT: w_next = LOAD_DONE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_loadData <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && w_fault)    r_loadData <= '0;
            if (r_state == LOAD_WAIT)   r_loadData <= w_fmt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_isStore   <= isStore;
            r_funct3    <= funct3;
            r_addr      <= w_addr_eff;
            r_storeData <= storeData;
        end
    end

    // Byte at offset k lives in word bits [31-8k:24-8k].
    always_comb begin
        for (int k = 0; k < 4; k++) w_rb[k] = ramDataOut[31-8*k -: 8];
    end

    assign w_off  = r_addr[1:0];
    assign w_byte = w_rb[w_off];
    assign w_half = {w_rb[{w_off[1], 1'b1}], w_rb[{w_off[1], 1'b0}]};

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_fmt = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_fmt = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            default: w_fmt = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
        endcase
    end

    // Read-modify-write: RAM word read at acceptance is on ramDataOut during STORE.
    always_comb begin
        w_wb = w_rb;
        case (r_funct3[1:0])
            2'b00: w_wb[w_off] = r_storeData[7:0];
            2'b01: begin
                w_wb[{w_off[1], 1'b0}] = r_storeData[7:0];
                w_wb[{w_off[1], 1'b1}] = r_storeData[15:8];
            end
            default: for (int k = 0; k < 4; k++) w_wb[k] = r_storeData[8*k +: 8];
        endcase
        ramDataIn = '0;
        for (int k = 0; k < 4; k++) ramDataIn[31-8*k -: 8] = w_wb[k];
    end

    assign reqReady        = (r_state == IDLE);
    assign done            = (r_state == LOAD_DONE) || (r_state == STORE) || (r_state == FAULT);
    assign accessFault     = (r_state == FAULT);
    assign loadData        = r_loadData;
    assign ramReadAddress  = (r_state == IDLE) ? address[BA_W-1:2] : r_addr[BA_W-1:2];
    assign ramWriteAddress = r_addr[BA_W-1:2];
    assign ramWriteEnable  = (r_state == STORE) && r_isStore && reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory plus a per-cycle completion scoreboard.
// Honours MEM_ACCESS_UNIT_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_access_unit;
    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;
    localparam int BYTES = WORDS * 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic          isStore = 1'b0;
    logic [2:0]    funct3 = 3'b0;
    logic [31:0]   address = 32'b0;
    logic [31:0]   storeData = 32'b0;
    logic          done, accessFault, ramWriteEnable;
    logic [31:0]   loadData, ramDataIn;
    logic [31:0]   ramDataOut = 32'b0;
    logic [AW-1:0] ramReadAddress, ramWriteAddress;

    mem_access_unit #(.RAM_A_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .isStore(isStore), .funct3(funct3), .address(address), .storeData(storeData),
        .done(done), .loadData(loadData), .accessFault(accessFault),
        .ramReadAddress(ramReadAddress), .ramDataOut(ramDataOut),
        .ramWriteAddress(ramWriteAddress), .ramDataIn(ramDataIn), .ramWriteEnable(ramWriteEnable)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [0:WORDS-1];
    always @(posedge clock) begin
        if (ramWriteEnable) ram[ramWriteAddress] <= ramDataIn;
        ramDataOut <= ram[ramReadAddress];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain byte memory, little-endian view for the requester.
    logic [7:0] bmem [0:BYTES-1];
    logic [31:0] mdl_ld = 32'b0;

    typedef struct { int acc; int due; bit st; bit flt; logic [31:0] data; } exp_t;
    exp_t q[$];

    function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal, mis;
        if (st) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = 1'b0;
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) mis = 1'b1;
        if (f3 == 3'd2 && a % 4 != 0) mis = 1'b1;
`endif
        return !legal || mis;
    endfunction

    function automatic logic [31:0] model_access(input bit st, input logic [2:0] f3,
                                                 input logic [31:0] a, input logic [31:0] sd);
        int ba, sz;
        logic [31:0] r;
        sz = (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2 ? 4 : 1);
        ba = int'(a % BYTES);
        ba = ba - (ba % sz);
        r = 32'b0;
        for (int i = 0; i < sz; i++) begin
            if (st) bmem[ba + i] = sd[8*i +: 8];
            else    r[8*i +: 8] = bmem[ba + i];
        end
        if (!st && f3 == 3'd0) r = {{24{r[7]}},  r[7:0]};
        if (!st && f3 == 3'd1) r = {{16{r[15]}}, r[15:0]};
        return r;
    endfunction

    // Per-cycle checker of the handshake/completion outputs against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            bit busy, edone;
            exp_t e;
            busy  = (q.size() > 0) && (cyc >= q[0].acc);
            edone = (q.size() > 0) && (cyc == q[0].due);
            chk("reqReady", {31'b0, reqReady}, {31'b0, !busy});
            chk("done", {31'b0, done}, {31'b0, edone});
            if (edone) begin
                e = q.pop_front();
                chk("accessFault", {31'b0, accessFault}, {31'b0, e.flt});
                chk("ramWriteEnable", {31'b0, ramWriteEnable}, {31'b0, e.st && !e.flt});
                if (!e.st || e.flt) mdl_ld = e.data;
            end else begin
                chk("accessFault_idle", {31'b0, accessFault}, 32'b0);
                chk("ramWriteEnable_idle", {31'b0, ramWriteEnable}, 32'b0);
            end
            chk("loadData", loadData, mdl_ld);
        end
    end

    // Issue one request from the IDLE cycle and return what the DUT reported on done.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output logic [31:0] d, output bit flt);
        exp_t e;
        bit seen;
        e.flt  = model_fault(st, f3, a);
        e.st   = st;
        e.acc  = cyc + 1;
        e.due  = cyc + 1 + ((!st && !e.flt) ? 1 : 0);
        e.data = e.flt ? 32'b0 : model_access(st, f3, a, sd);
        q.push_back(e);
        reqValid = 1'b1; isStore = st; funct3 = f3; address = a; storeData = sd;
        @(posedge clock); #1;
        reqValid = 1'b0; address = $urandom; storeData = $urandom;
        seen = 1'b0; d = 32'b0; flt = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clock);
            if (done) begin seen = 1'b1; d = loadData; flt = accessFault; end
        end
        if (!seen) begin
            total++;
            $display("FAIL timeout: got no done expected done within 5 cycles for addr %h", a);
            q.delete();
        end
        @(posedge clock); #1;
    endtask

    logic [31:0] d, w8;
    bit          f;

    initial begin
        for (int w = 0; w < WORDS; w++) ram[w] = $urandom;
        ram[5] = 32'h88223344;
        for (int w = 0; w < WORDS; w++)
            for (int k = 0; k < 4; k++) bmem[4*w + k] = ram[w][31-8*k -: 8];

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_done", {31'b0, done}, 32'b0);
        chk("rst_fault", {31'b0, accessFault}, 32'b0);
        chk("rst_loadData", loadData, 32'b0);
        chk("rst_we", {31'b0, ramWriteEnable}, 32'b0);
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock);
        chk("rst_ready_first", {31'b0, reqReady}, 32'b1);
        @(posedge clock); #1;

        issue(0, 3'b010, 32'h14, 0, d, f); chk("LW_0x14", d, 32'h44332288);
        chk("LW_0x14_fault", {31'b0, f}, 32'b0);
        issue(0, 3'b000, 32'h14, 0, d, f); chk("LB_0x14", d, 32'hFFFFFF88);
        issue(0, 3'b100, 32'h14, 0, d, f); chk("LBU_0x14", d, 32'h00000088);
        issue(0, 3'b001, 32'h16, 0, d, f); chk("LH_0x16", d, 32'h00004433);
        issue(1, 3'b000, 32'h15, 32'h000000AB, d, f);
        chk("SB_word5", ram[5], 32'h88AB3344);
        issue(0, 3'b010, 32'h14, 0, d, f); chk("LW_after_SB", d, 32'h4433AB88);
        issue(1, 3'b001, 32'h15, 32'h0000BEEF, d, f);
`ifdef MEM_ACCESS_UNIT_MISALIGN_TRAP_EN
        chk("SH_mis_fault", {31'b0, f}, 32'b1);
        chk("SH_mis_word5", ram[5], 32'h88AB3344);
`else
        chk("SH_mis_fault", {31'b0, f}, 32'b0);
        chk("SH_mis_word5", ram[5], 32'hEFBE3344);
`endif
        issue(0, 3'b110, 32'h14, 0, d, f);
        chk("ill_ld_fault", {31'b0, f}, 32'b1);
        chk("ill_ld_data", d, 32'b0);
        issue(1, 3'b100, 32'h20, 32'hFFFFFFFF, d, f);
        chk("ill_st_fault", {31'b0, f}, 32'b1);
        issue(1, 3'b010, 32'h20, 32'h12345678, d, f);
        chk("SW_word8", ram[8], 32'h78563412);
        issue(0, 3'b010, 32'h20, 0, d, f); chk("LW_0x20", d, 32'h12345678);
        issue(1, 3'b001, 32'h22, 32'h0000A5C3, d, f);
        issue(0, 3'b001, 32'h22, 0, d, f); chk("LH_0x22", d, 32'hFFFFA5C3);
        issue(0, 3'b101, 32'h22, 0, d, f); chk("LHU_0x22", d, 32'h0000A5C3);
        issue(0, 3'b000, 32'h23, 0, d, f); chk("LB_0x23", d, 32'hFFFFFFA5);
        issue(0, 3'b010, 32'h80004020, 0, d, f); chk("LW_wrap", d, 32'hA5C35678);
        issue(0, 3'b010, 32'h23, 0, d, f);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'h40 + $urandom_range(0, 31);
            if (n % 5 == 0) a = a | 32'hC0004000;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, d, f);
        end

        // Reset landing on the STORE cycle must suppress the write.
        w8 = ram[8];
        reqValid = 1'b1; isStore = 1'b1; funct3 = 3'b010; address = 32'h20; storeData = 32'hDEADBEEF;
        @(posedge clock); #1;
        reqValid = 1'b0; reset = 1'b0; mdl_ld = 32'b0;
        @(negedge clock);
        chk("rst_store_we", {31'b0, ramWriteEnable}, 32'b0);
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock);
        chk("rst_store_ready", {31'b0, reqReady}, 32'b1);
        chk("rst_store_ld", loadData, 32'b0);
        @(posedge clock); #1;
        chk("rst_store_word8", ram[8], w8);
        issue(0, 3'b010, 32'h20, 0, d, f);
        chk("rst_store_LW", d, {w8[7:0], w8[15:8], w8[23:16], w8[31:24]});

        begin
            int bad;
            bad = 0;
            for (int w = 0; w < WORDS; w++)
                if (ram[w] !== {bmem[4*w], bmem[4*w+1], bmem[4*w+2], bmem[4*w+3]}) bad++;
            chk("ram_vs_model_words", bad, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1);
    end
endmodule
